// File: rtl/inst_seq_pkg.sv
// inst_sequencer shared types and defaults.
// Optional loop feature: define INST_SEQ_LOOP_EN.
package inst_seq_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 4;
  localparam int DEF_IW    = 32;

  localparam logic [31:0] NOP = 32'h0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

endpackage

// File: rtl/inst_seq_mem.sv
// Instruction store: register array, sync write, async read.
// Contents are deliberately not reset.
module inst_seq_mem
  import inst_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int IW    = DEF_IW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_sequencer.sv
// Program sequencer feeding the cpu instruction input.
// Optional loop feature: define INST_SEQ_LOOP_EN.
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int IW    = DEF_IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          step,
  input  logic          halt,
`ifdef INST_SEQ_LOOP_EN
  input  logic [AW-1:0] loop_start,
  input  logic [AW-1:0] loop_end,
  input  logic [7:0]    loop_count,
`endif
  output logic [IW-1:0] inst,
  output logic          inst_valid,
  output logic [AW:0]   pc,
  output logic          busy,
  output logic          done
);

  localparam logic [AW:0] ONE = (AW+1)'(1);

  state_t        state;
  state_t        s_n;
  state_t        adv;
  logic [AW:0]   len;
  logic [AW:0]   pc_n;
  logic [AW:0]   a_pc;
  logic [AW:0]   a_len;
  logic [AW:0]   nxt;
  logic [IW-1:0] rdata;
  logic          idle_like;
  logic          go;
  logic          issue;
  logic          lat;
  logic          last;

  // From IDLE/DONE a new run starts at 0 with freshly sampled config
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign a_pc      = idle_like ? '0 : pc;
  assign a_len     = idle_like ? prog_len : len;
  assign go        = !halt && (start || step);
  assign last      = (nxt == a_len);
  assign adv       = last ? S_DONE : (step ? S_PAUSE : S_RUN);

`ifdef INST_SEQ_LOOP_EN
  logic [AW-1:0] ls, le, a_ls, a_le;
  logic [7:0]    lc, iter, a_lc, a_iter;
  logic          lok, a_ok, wrap;

  always_comb begin
    if (idle_like) begin
      a_ls   = loop_start;
      a_le   = loop_end;
      a_lc   = loop_count;
      a_iter = '0;
      a_ok   = ({1'b0, loop_end} < prog_len) &&
               (loop_start <= loop_end);
    end else begin
      a_ls   = ls;
      a_le   = le;
      a_lc   = lc;
      a_iter = iter;
      a_ok   = lok;
    end
    wrap = a_ok && (a_pc == {1'b0, a_le}) && (a_iter < a_lc);
    nxt  = wrap ? {1'b0, a_ls} : a_pc + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls   <= '0;
      le   <= '0;
      lc   <= '0;
      lok  <= 1'b0;
      iter <= '0;
    end else begin
      if (lat) begin
        ls  <= a_ls;
        le  <= a_le;
        lc  <= a_lc;
        lok <= a_ok;
      end
      if (lat || issue)
        iter <= a_iter + {7'd0, issue && wrap};
    end
  end
`else
  assign nxt = a_pc + ONE;
`endif

  always_comb begin
    s_n   = state;
    pc_n  = pc;
    issue = 1'b0;
    lat   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (go) begin
          lat = 1'b1;
          if (prog_len == '0) begin
            s_n  = S_DONE;
            pc_n = '0;
          end else begin
            issue = 1'b1;
            pc_n  = nxt;
            s_n   = adv;
          end
        end
      end
      S_RUN: begin
        if (halt) begin
          s_n = S_PAUSE;
        end else begin
          issue = 1'b1;
          pc_n  = nxt;
          s_n   = adv;
        end
      end
      S_PAUSE: begin
        if (halt) begin
          s_n  = S_IDLE;
          pc_n = '0;
        end else if (go) begin
          issue = 1'b1;
          pc_n  = nxt;
          s_n   = adv;
        end
      end
      default: s_n = S_IDLE;
    endcase
  end

  inst_seq_mem #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .IW   (IW)
  ) u_mem (
    .clk  (clk),
    .we   (load_we && idle_like),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(a_pc[AW-1:0]),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      inst       <= '0;
      inst_valid <= 1'b0;
      pc         <= '0;
      len        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= s_n;
      busy       <= (s_n == S_RUN);
      done       <= (s_n == S_DONE);
      inst_valid <= issue;
      inst       <= issue ? rdata : IW'(NOP);
      pc         <= pc_n;
      if (lat) len <= prog_len;
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Directed + randomized bench for inst_sequencer
// against a program-position reference model.
module tb_inst_sequencer;

  localparam int AW = 4;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          halt = 1'b0;
`ifdef INST_SEQ_LOOP_EN
  logic [AW-1:0] loop_start = '0;
  logic [AW-1:0] loop_end = '0;
  logic [7:0]    loop_count = '0;
`endif
  logic [IW-1:0] inst;
  logic          inst_valid;
  logic [AW:0]   pc;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data),
    .prog_len  (prog_len),
    .start     (start),
    .step      (step),
    .halt      (halt),
`ifdef INST_SEQ_LOOP_EN
    .loop_start(loop_start),
    .loop_end  (loop_end),
    .loop_count(loop_count),
`endif
    .inst      (inst),
    .inst_valid(inst_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  // Reference model: program position and a mode word
  logic [IW-1:0] m_mem [16];
  string         mode = "idle";
  int            m_len = 0;
  int            m_pos = 0;
  logic [IW-1:0] e_inst = '0;
  logic          e_valid = 1'b0;
  int            e_pc = 0;
  logic          e_busy = 1'b0;
  logic          e_done = 1'b0;

  logic [IW-1:0] prog [4];

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit iss = 1'b0;
    bit can_load = (mode == "idle") || (mode == "done");
    bit go = !halt && (start || step);
    if (can_load && go) begin
      m_len = int'(prog_len);
      m_pos = 0;
      if (m_len == 0) mode = "done";
      else begin
        iss = 1'b1;
        mode = step ? "pause" : "run";
      end
    end else if (mode == "run" && halt) begin
      mode = "pause";
    end else if (mode == "run") begin
      iss = 1'b1;
      if (step) mode = "pause";
    end else if (mode == "pause" && halt) begin
      mode = "idle";
      m_pos = 0;
    end else if (mode == "pause" && go) begin
      iss = 1'b1;
      mode = step ? "pause" : "run";
    end
    e_inst = iss ? m_mem[m_pos] : '0;
    if (iss) begin
      m_pos++;
      if (m_pos == m_len) mode = "done";
    end
    e_valid = iss;
    e_pc    = m_pos;
    e_busy  = (mode == "run");
    e_done  = (mode == "done");
    if (can_load && load_we) m_mem[load_addr] = load_data;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("inst", inst, e_inst);
    chk("valid", 32'(inst_valid), 32'(e_valid));
    chk("pc", 32'(pc), 32'(e_pc));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    mode = "idle";
    m_pos = 0;
    m_len = 0;
    e_inst = '0;
    e_valid = 1'b0;
    e_pc = 0;
    e_busy = 1'b0;
    e_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_valid", 32'(inst_valid), 32'h0);
    chk("rst_hold_done", 32'(done), 32'h0);
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic load(int a, logic [IW-1:0] d);
    load_we = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    cycle();
    load_we = 1'b0;
  endtask

  initial begin
    prog[0] = 32'h20010001;
    prog[1] = 32'h20020001;
    prog[2] = 32'h00220820;
    prog[3] = 32'h00221020;

    do_reset();
    repeat (5) begin
      cycle();
      chk("idle_inst", inst, 32'h0);
    end

    for (int i = 0; i < 4; i++) load(i, prog[i]);

    // straight run
    prog_len = 5'd4;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("run0", inst, prog[0]);
    for (int i = 1; i < 4; i++) begin
      cycle();
      chk("run_seq", inst, prog[i]);
    end
    cycle();
    chk("run_done", 32'(done), 32'h1);
    chk("run_pc", 32'(pc), 32'h4);

    // halt on second issue, then resume
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    halt = 1'b1;
    cycle();
    halt = 1'b0;
    chk("halt_pc", 32'(pc), 32'h2);
    chk("halt_valid", 32'(inst_valid), 32'h0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("resume", inst, 32'h00220820);
    cycle();
    chk("resume_end", 32'(done), 32'h1);

    // single-step from IDLE; store survives reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      cycle();
      step = 1'b0;
      chk("step_inst", inst, prog[i]);
      cycle();
      chk("step_gap", 32'(inst_valid), 32'h0);
    end
    chk("step_done", 32'(done), 32'h1);

    // empty program
    prog_len = '0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("empty_done", 32'(done), 32'h1);
    repeat (2) cycle();

    // load attempt while running is dropped
    prog_len = 5'd4;
    start = 1'b1;
    cycle();
    start = 1'b0;
    load_we = 1'b1;
    load_addr = 4'd2;
    load_data = 32'hDEADBEEF;
    cycle();
    load_we = 1'b0;
    repeat (2) cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (2) cycle();
    chk("store_kept", inst, 32'h00220820);
    cycle();

    // mid-run reset aborts
    start = 1'b1;
    cycle();
    start = 1'b0;
    do_reset();
    cycle();

    // randomized
    for (int i = 0; i < 16; i++) load(i, $urandom);
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      step = ($urandom_range(0, 9) == 0);
      halt = ($urandom_range(0, 15) == 0);
      load_we = ($urandom_range(0, 3) == 0);
      load_addr = AW'($urandom);
      load_data = $urandom;
      if ($urandom_range(0, 19) == 0)
        prog_len = 5'($urandom_range(0, 16));
      if ($urandom_range(0, 499) == 0) do_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
